// File: rtl/uart_receiver_pkg.sv
// Shared types and constants for the 8N1 UART receiver.
package uart_receiver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;

  // Clocks per oversample tick, truncated, never below one.
  function automatic int calc_div(input int clock_rate, input int baud_rate);
    int d;
    d = clock_rate / (baud_rate * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/uart_receiver_baud_tick.sv
// 16x oversample tick generator: down-counter with terminal-count compare.
module uart_baud_tick
  import uart_receiver_pkg::*;
#(
  parameter int CLOCK_RATE = 10000,
  parameter int BAUD_RATE  = 300
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int DIV = calc_div(CLOCK_RATE, BAUD_RATE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Clear parks the counter at terminal count so the first tick follows immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0) && !clear;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling and a ready/valid output register.
//   state | meaning
//   IDLE  | waiting for a falling edge on the synchronized line
//   START | checking the start bit at mid-bit
//   DATA  | sampling 8 data bits, LSB first
//   STOP  | checking stop bit; on framing error waits for line high
module uart_receiver
  import uart_receiver_pkg::*;
#(
  parameter int CLOCK_RATE = 10000,
  parameter int BAUD_RATE  = 300
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 in,
  input  logic                 ready,
  output logic [DATA_BITS-1:0] out,
  output logic                 valid
);

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);

  logic rx_meta, rx_sync, rx_prev;
  logic fall;
  logic tick, clear_div;

  rx_state_t state, state_n;
  logic [3:0] tick_cnt, tick_cnt_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic stop_err, stop_err_n;
  logic load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= in;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign fall = rx_prev && !rx_sync;

  uart_baud_tick #(
    .CLOCK_RATE(CLOCK_RATE),
    .BAUD_RATE (BAUD_RATE)
  ) u_baud_tick (
    .clk  (clk),
    .reset(reset),
    .clear(clear_div),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      stop_err <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      stop_err <= stop_err_n;
    end
  end

  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    stop_err_n = stop_err;
    load       = 1'b0;
    clear_div  = 1'b0;

    if (!enable) begin
      state_n    = IDLE;
      tick_cnt_n = '0;
      bit_cnt_n  = '0;
      stop_err_n = 1'b0;
      clear_div  = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (fall) begin
            state_n    = START;
            tick_cnt_n = '0;
            bit_cnt_n  = '0;
            clear_div  = 1'b1;
          end
        end
        START: begin
          if (tick) begin
            if (tick_cnt == TICK_MID) begin
              tick_cnt_n = '0;
              state_n    = rx_sync ? IDLE : DATA;
            end else begin
              tick_cnt_n = tick_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt_n = '0;
              shift_n    = {rx_sync, shift[DATA_BITS-1:1]};
              if (bit_cnt == BIT_LAST) begin
                bit_cnt_n = '0;
                state_n   = STOP;
              end else begin
                bit_cnt_n = bit_cnt + 3'd1;
              end
            end else begin
              tick_cnt_n = tick_cnt + 4'd1;
            end
          end
        end
        STOP: begin
          // A low stop bit drops the byte; a new start is only trusted after idle high.
          if (stop_err) begin
            if (rx_sync) begin
              stop_err_n = 1'b0;
              state_n    = IDLE;
            end
          end else if (tick) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt_n = '0;
              if (rx_sync) begin
                load    = 1'b1;
                state_n = IDLE;
              end else begin
                stop_err_n = 1'b1;
              end
            end else begin
              tick_cnt_n = tick_cnt + 4'd1;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // A completing byte takes priority over the consumer handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      out   <= shift;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver at default parameters.
module tb_uart_receiver;

  localparam int BIT_CLK = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic       line = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] out_b;
  logic       valid;

  int checks = 0;
  int errors = 0;
  int rises = 0;
  int lat_meas = 306;
  logic       valid_q = 1'b0;
  logic [7:0] last_byte = 8'h00;

  uart_receiver dut (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .in    (line),
    .ready (ready),
    .out   (out_b),
    .valid (valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid && !valid_q) begin
      rises = rises + 1;
      last_byte = out_b;
    end
    valid_q = valid;
  end

  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    line = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      line = data[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    line = stop_bit;
    repeat (BIT_CLK) @(negedge clk);
    line = 1'b1;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ready();
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    gap(3);
    checks++; if (out_b !== 8'h00) begin errors++; $display("FAIL reset_out: got %h want 00", out_b); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
    reset = 1'b1;
    gap(10);
  endtask

  task automatic test_single_aa();
    int lat;
    ready = 1'b1;
    lat = 0;
    fork
      send_frame(8'hAA, 1'b1);
      begin
        do begin
          @(negedge clk);
          lat++;
        end while (!valid && lat < 400);
        checks++; if (!(lat >= 300 && lat <= 308)) begin errors++; $display("FAIL latency_aa: got %0d clk want 300..308", lat); end
        lat_meas = lat;
        checks++; if (out_b !== 8'hAA) begin errors++; $display("FAIL out_aa: got %h want aa", out_b); end
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL pulse_aa: valid %b want 0 one cycle later", valid); end
      end
    join
    gap(40);
  endtask

  task automatic test_hold_01();
    ready = 1'b0;
    send_frame(8'h01, 1'b1);
    gap(10);
    checks++; if (valid !== 1'b1 || out_b !== 8'h01) begin errors++; $display("FAIL hold_01: got valid %b out %h want 1/01", valid, out_b); end
    gap(200);
    checks++; if (valid !== 1'b1 || out_b !== 8'h01) begin errors++; $display("FAIL hold_01_long: got valid %b out %h want 1/01", valid, out_b); end
    pulse_ready();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL handshake_01: valid %b want 0", valid); end
    checks++; if (out_b !== 8'h01) begin errors++; $display("FAIL handshake_out_01: got %h want 01", out_b); end
    gap(20);
  endtask

  task automatic test_overrun();
    ready = 1'b0;
    send_frame(8'hAA, 1'b1);
    checks++; if (valid !== 1'b1 || out_b !== 8'hAA) begin errors++; $display("FAIL overrun_first: got valid %b out %h want 1/aa", valid, out_b); end
    send_frame(8'h01, 1'b1);
    gap(20);
    checks++; if (valid !== 1'b1 || out_b !== 8'h01) begin errors++; $display("FAIL overrun_second: got valid %b out %h want 1/01", valid, out_b); end
  endtask

  task automatic test_simultaneous();
    ready = 1'b0;
    fork
      send_frame(8'h3C, 1'b1);
      begin
        repeat (lat_meas - 1) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        checks++; if (valid !== 1'b1 || out_b !== 8'h3C) begin errors++; $display("FAIL simultaneous: got valid %b out %h want 1/3c", valid, out_b); end
      end
    join
    pulse_ready();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL simultaneous_clear: valid %b want 0", valid); end
    ready = 1'b1;
    gap(20);
  endtask

  task automatic test_glitch();
    int r0;
    ready = 1'b1;
    r0 = rises;
    line = 1'b0;
    gap(4);
    line = 1'b1;
    gap(100);
    checks++; if (valid !== 1'b0 || rises != r0) begin errors++; $display("FAIL glitch: valid %b rises %0d want 0/%0d", valid, rises, r0); end
    send_frame(8'h55, 1'b1);
    gap(20);
    checks++; if (rises != r0 + 1 || last_byte !== 8'h55) begin errors++; $display("FAIL after_glitch: rises %0d byte %h want %0d/55", rises, last_byte, r0 + 1); end
  endtask

  task automatic test_framing();
    int r0;
    r0 = rises;
    send_frame(8'hF0, 1'b0);
    gap(40);
    checks++; if (rises != r0 || out_b !== 8'h55) begin errors++; $display("FAIL framing: rises %0d out %h want %0d/55", rises, out_b, r0); end
    send_frame(8'h0F, 1'b1);
    gap(20);
    checks++; if (rises != r0 + 1 || last_byte !== 8'h0F) begin errors++; $display("FAIL after_framing: rises %0d byte %h want %0d/0f", rises, last_byte, r0 + 1); end
  endtask

  task automatic test_reset_mid();
    int r0;
    r0 = rises;
    fork
      send_frame(8'h5A, 1'b1);
      begin
        gap(120);
        reset = 1'b0;
      end
    join
    gap(5);
    reset = 1'b1;
    gap(20);
    checks++; if (rises != r0 || valid !== 1'b0 || out_b !== 8'h00) begin errors++; $display("FAIL reset_mid: rises %0d valid %b out %h want %0d/0/00", rises, valid, out_b, r0); end
    send_frame(8'hC3, 1'b1);
    gap(20);
    checks++; if (rises != r0 + 1 || last_byte !== 8'hC3) begin errors++; $display("FAIL after_reset_mid: rises %0d byte %h want %0d/c3", rises, last_byte, r0 + 1); end
  endtask

  task automatic test_enable_mid();
    int r0;
    r0 = rises;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        gap(150);
        enable = 1'b0;
      end
    join
    gap(20);
    enable = 1'b1;
    gap(20);
    checks++; if (rises != r0 || out_b !== 8'hC3) begin errors++; $display("FAIL enable_mid: rises %0d out %h want %0d/c3", rises, out_b, r0); end
    send_frame(8'hC3, 1'b1);
    gap(20);
    checks++; if (rises != r0 + 1 || last_byte !== 8'hC3) begin errors++; $display("FAIL after_enable_mid: rises %0d byte %h want %0d/c3", rises, last_byte, r0 + 1); end
  endtask

  initial begin
    test_reset();
    test_single_aa();
    test_hold_01();
    test_overrun();
    test_simultaneous();
    test_glitch();
    test_framing();
    test_reset_mid();
    test_enable_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLOCK_RATE, default 10000, meaning clk frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 300, meaning serial bit rate in bits/s.
REQ-003 Port clk  input  1  single clock; all logic rising-edge triggered.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port enable  input  1  receiver enable; 1 = receive.
REQ-006 Port in  input  1  asynchronous serial line; idle high.
REQ-007 Port ready  input  1  consumer can accept the current byte.
REQ-008 Port out  output  8  last received data byte.
REQ-009 Port valid  output  1  out holds an unconsumed byte.

Function
REQ-010 Frame format SHALL be 8N1: one low start bit, 8 data bits LSB first, one high stop bit, no parity.
REQ-011 The receiver SHALL use 16x oversampling; tick divider DIV = CLOCK_RATE/(BAUD_RATE*16), integer-truncated, minimum 1 (defaults: DIV=2, 32 clk per bit).
REQ-012 The tick counter SHALL reset to 0 on a start-edge detect so that sampling is phase-aligned to each frame.
REQ-013 in SHALL pass through a 2-flop synchronizer before use; both flops reset to 1.
REQ-014 States SHALL be IDLE, START, DATA, STOP.
REQ-015 IDLE: a synchronized high-to-low transition moves to START.
REQ-016 START: at tick 8, if the line is low go to DATA, else treat as a glitch and return to IDLE.
REQ-017 DATA: every 16 ticks, sample one bit into the shift register LSB first; after the 8th bit go to STOP.
REQ-018 STOP: 16 ticks later, if the line is high, load the shift register into out, set valid to 1, and go to IDLE.
REQ-019 STOP with the line low (framing error): discard the byte, leave out and valid unchanged, and return to IDLE only after the line is seen high.
REQ-020 valid SHALL be cleared on the clock edge where valid && ready.
REQ-021 valid SHALL stay 1 and out SHALL stay stable while ready is 0.
REQ-022 Overrun: a new byte completing while valid=1 SHALL overwrite out and keep valid at 1; the older byte is lost.
REQ-023 Simultaneous completion and handshake: the new byte wins; out updates and valid stays 1.
REQ-024 enable=0 SHALL force IDLE and abort any frame in progress; out and valid are retained, and the handshake per REQ-020 still works.
REQ-025 Latency: valid SHALL rise within 304 +/- 4 clk after the start edge on in (defaults: 152 ticks plus synchronizer and register delay).

Reset
REQ-026 Assertion of reset (low) SHALL immediately set state to IDLE, out to 8'h00, valid to 0, tick and bit counters to 0, and the shift register to 0.
REQ-027 Reset mid-frame SHALL discard the partial frame; after deassertion, reception resumes on the next valid start edge.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE/START/DATA/STOP), DATA_BITS=8 and OVERSAMPLE=16.
REQ-029 One sub-module, uart_baud_tick, SHALL generate the 16x tick enable from CLOCK_RATE and BAUD_RATE, with a synchronous clear input.
REQ-030 The top level SHALL contain the synchronizer, the FSM, the shift register and the out/valid holding register.

Verification
REQ-031 Default parameters, ready=1, send 8'hAA -> out=8'hAA and a one-cycle valid pulse within 304 +/- 4 clk of the start edge.
REQ-032 ready=0, send 8'h01 -> valid=1 and out=8'h01 held indefinitely; raise ready for 1 clk -> valid=0 on the next edge.
REQ-033 ready=0, send 8'hAA then 8'h01 back-to-back -> out=8'h01, valid=1 (overrun overwrite).
REQ-034 Low glitch of 4 clk on an idle line -> no state change past START, valid stays 0; a following 8'h55 frame is received correctly.
REQ-035 Frame 8'hF0 with stop bit forced low -> valid stays 0 and out is unchanged; the next good frame 8'h0F is received.
REQ-036 Assert reset in the middle of the DATA state, or drop enable mid-frame -> no byte delivered, and the next frame 8'hC3 is received correctly.
